// File: rtl/seq_pkg.sv
// Shared types and default parameter values for the fetch sequencer.
// The FSM encoding is fixed at 3 bits so it can be probed and compared directly.
package seq_pkg;

  typedef enum logic [2:0] {
    RESET  = 3'd0,
    FETCH  = 3'd1,
    ISSUE  = 3'd2,
    EXEC   = 3'd3,
    HALTED = 3'd4
  } seq_state_t;

  localparam int DEF_PC_W       = 8;
  localparam int DEF_INSTR_W    = 9;
  localparam int DEF_CNT_W      = 16;
  localparam int DEF_START_ADDR = 0;

endpackage

// File: rtl/fetch_sequencer_sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         start_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] MAX = {W{1'b1}};

  always_ff @(posedge CLK) begin
    if (!start_n) begin
      count <= '0;
    end else if (inc && (count != MAX)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch/issue/execute sequencer with sticky halt and saturating counters.
// All outputs come from registers; no input reaches an output combinationally.
module fetch_sequencer
  import seq_pkg::*;
#(
  parameter int PC_W       = DEF_PC_W,
  parameter int INSTR_W    = DEF_INSTR_W,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int START_ADDR = DEF_START_ADDR
) (
  input  logic               CLK,
  input  logic               start_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               exec_done,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  input  logic               halt_req,
  output logic               halted,
  output logic [CNT_W-1:0]   inst_count,
  output logic [CNT_W-1:0]   cycle_count
);

  localparam logic [PC_W-1:0] START_PC = START_ADDR[PC_W-1:0];
  localparam logic [PC_W-1:0] PC_ONE   = {{(PC_W-1){1'b0}}, 1'b1};

  seq_state_t      state;
  logic [PC_W-1:0] pc;
  logic            retire;
  logic            active;

  assign imem_addr = pc;
  assign retire    = (state == EXEC) && exec_done;
  assign active    = (state == FETCH) || (state == ISSUE) || (state == EXEC);

  // Status outputs are loaded with the value matching the state being entered.
  always_ff @(posedge CLK) begin
    if (!start_n) begin
      state       <= RESET;
      pc          <= START_PC;
      instr       <= '0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      instr_valid <= 1'b0;
      case (state)
        RESET: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          if (imem_valid) begin
            instr       <= imem_data;
            state       <= ISSUE;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
          end
        end
        ISSUE: begin
          state <= EXEC;
        end
        EXEC: begin
          if (exec_done) begin
            if (halt_req) begin
              state  <= HALTED;
              halted <= 1'b1;
            end else begin
              state    <= FETCH;
              imem_req <= 1'b1;
              pc       <= branch_taken ? branch_target : pc + PC_ONE;
            end
          end
        end
        HALTED: begin
          state <= HALTED;
        end
        default: begin
          state    <= RESET;
          imem_req <= 1'b0;
          halted   <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_inst_cnt (
    .CLK     (CLK),
    .start_n (start_n),
    .inc     (retire),
    .count   (inst_count)
  );

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .CLK     (CLK),
    .start_n (start_n),
    .inc     (active),
    .count   (cycle_count)
  );

endmodule
